intermediator_mem_blocks: RTL and testbench

Storage primitives bundle for the SpMV MAC intermediator. It contains three independent sub-blocks behind one clock and reset:
- a 2-port registered-read block RAM holding partial sums;
- a 2-port toggle (XOR) occupancy bit array that marks which rows hold a stored partial sum;
- a synchronous FIFO with count and almost-full, used for overflow queues.

The intermediator pipeline instantiates these as its memory and occupancy tables and its overflow queues.

---
 rtl/intermediator_mem_blocks.sv | 151 +++++++++++++++
 tb/tb_intermediator_mem_blocks.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intermediator_mem_blocks.sv
// intermediator_mem_blocks
//   Storage primitives for the SpMV MAC intermediator, sharing one clock and
//   a synchronous active-high reset:
//     - 2-port read-first block RAM (partial sums), registered read data
//     - 2-port toggle (XOR) occupancy bit array, combinational read
//     - synchronous FIFO with count / almost flags (overflow queues)
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   ram_we*/ram_addr*/ram_d*       RAM write enable / address / write data
//   ram_q0, ram_q1                 RAM read data, 1-cycle latency
//   occ_we*/occ_addr*              occupancy toggle enable / address
//   occ_q0, occ_q1                 occupancy bit at address, pre-edge value
//   fifo_push/fifo_pop/fifo_d      FIFO enqueue / dequeue / push data
//   fifo_q                         last popped entry (registered)
//   fifo_full/empty/count          FIFO status
//   fifo_almost_empty/almost_full  count <= 1 / count >= ALMOST_FULL_COUNT
//
// Optional macro INTERMEDIATOR_MEM_CHECK_EN enables simulation-only ERROR
// messages for FIFO overflow/underflow attempts and RAM write collisions.
module intermediator_mem_blocks #(
    parameter int RAM_WIDTH         = 66,
    parameter int DEPTH             = 1024,
    parameter int FIFO_WIDTH        = 66,
    parameter int FIFO_DEPTH        = 32,
    parameter int ALMOST_FULL_COUNT = FIFO_DEPTH / 2,
    localparam int AW               = $clog2(DEPTH),
    localparam int CW               = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    // block RAM
    input  logic                  ram_we0,
    input  logic                  ram_we1,
    input  logic [AW-1:0]         ram_addr0,
    input  logic [AW-1:0]         ram_addr1,
    input  logic [RAM_WIDTH-1:0]  ram_d0,
    input  logic [RAM_WIDTH-1:0]  ram_d1,
    output logic [RAM_WIDTH-1:0]  ram_q0,
    output logic [RAM_WIDTH-1:0]  ram_q1,
    // occupancy array
    input  logic                  occ_we0,
    input  logic                  occ_we1,
    input  logic [AW-1:0]         occ_addr0,
    input  logic [AW-1:0]         occ_addr1,
    output logic                  occ_q0,
    output logic                  occ_q1,
    // FIFO
    input  logic                  fifo_push,
    input  logic                  fifo_pop,
    input  logic [FIFO_WIDTH-1:0] fifo_d,
    output logic [FIFO_WIDTH-1:0] fifo_q,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [CW-1:0]         fifo_count,
    output logic                  fifo_almost_empty,
    output logic                  fifo_almost_full
);

    localparam int PW = $clog2(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Block RAM: read-first on both ports. Port 1's write is issued after
    // port 0's, so on an address collision port 1's data lands.
    // ------------------------------------------------------------------
    logic [RAM_WIDTH-1:0] ram_mem [DEPTH];

    always_ff @(posedge clk) begin
        ram_q0 <= ram_mem[ram_addr0];
        ram_q1 <= ram_mem[ram_addr1];
        if (ram_we0) ram_mem[ram_addr0] <= ram_d0;
        if (ram_we1) ram_mem[ram_addr1] <= ram_d1;
    end

    // ------------------------------------------------------------------
    // Occupancy array: each port contributes a one-hot toggle mask; XORing
    // the masks makes a same-address double toggle cancel out.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] occ_bits;
    logic [DEPTH-1:0] occ_tog;

    assign occ_tog = ({{(DEPTH-1){1'b0}}, occ_we0} << occ_addr0)
                   ^ ({{(DEPTH-1){1'b0}}, occ_we1} << occ_addr1);

    always_ff @(posedge clk) begin
        if (rst) occ_bits <= '0;
        else     occ_bits <= occ_bits ^ occ_tog;
    end

    assign occ_q0 = occ_bits[occ_addr0];
    assign occ_q1 = occ_bits[occ_addr1];

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [FIFO_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    assign fifo_empty        = (fifo_count == '0);
    assign fifo_full         = (fifo_count == CW'(FIFO_DEPTH));
    assign fifo_almost_empty = (fifo_count <= CW'(1));
    assign fifo_almost_full  = (fifo_count >= CW'(ALMOST_FULL_COUNT));

    // A pop frees the head slot on the same edge, so a push into a full
    // FIFO is taken when it is paired with a pop.
    assign do_pop  = fifo_pop  && !fifo_empty;
    assign do_push = fifo_push && (!fifo_full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr] <= fifo_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_q     <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                fifo_q <= fifo_mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef INTERMEDIATOR_MEM_CHECK_EN
    // Simulation-only diagnostics; they do not affect any state.
    always @(posedge clk) begin
        if (!rst) begin
            if (fifo_push && fifo_full)
                $display("ERROR %0t intermediator_mem_blocks: FIFO push while full", $time);
            if (fifo_pop && fifo_empty)
                $display("ERROR %0t intermediator_mem_blocks: FIFO pop while empty", $time);
            if (ram_we0 && ram_we1 && (ram_addr0 == ram_addr1))
                $display("ERROR %0t intermediator_mem_blocks: both RAM ports write addr %0d",
                         $time, ram_addr0);
        end
    end
`else
    // No diagnostics in the default build.
`endif

endmodule

// File: tb/tb_intermediator_mem_blocks.sv
module tb_intermediator_mem_blocks;

    localparam int RW = 66;
    localparam int AW = 10;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          ram_we0, ram_we1;
    logic [AW-1:0] ram_addr0, ram_addr1;
    logic [RW-1:0] ram_d0, ram_d1, ram_q0, ram_q1;
    logic          occ_we0, occ_we1;
    logic [AW-1:0] occ_addr0, occ_addr1;
    logic          occ_q0, occ_q1;
    logic          fifo_push, fifo_pop;
    logic [RW-1:0] fifo_d, fifo_q;
    logic          fifo_full, fifo_empty, fifo_almost_empty, fifo_almost_full;
    logic [CW-1:0] fifo_count;

    intermediator_mem_blocks dut (
        .clk(clk), .rst(rst),
        .ram_we0(ram_we0), .ram_we1(ram_we1),
        .ram_addr0(ram_addr0), .ram_addr1(ram_addr1),
        .ram_d0(ram_d0), .ram_d1(ram_d1),
        .ram_q0(ram_q0), .ram_q1(ram_q1),
        .occ_we0(occ_we0), .occ_we1(occ_we1),
        .occ_addr0(occ_addr0), .occ_addr1(occ_addr1),
        .occ_q0(occ_q0), .occ_q1(occ_q1),
        .fifo_push(fifo_push), .fifo_pop(fifo_pop), .fifo_d(fifo_d),
        .fifo_q(fifo_q), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count), .fifo_almost_empty(fifo_almost_empty),
        .fifo_almost_full(fifo_almost_full)
    );

    always #5 clk = ~clk;

    // Scoreboard: each entry names a DUT output, the cycle at whose falling
    // edge it must be checked, and its hand-computed value.
    typedef enum int {S_RQ0, S_RQ1, S_OQ0, S_OQ1, S_FQ, S_CNT,
                      S_EMP, S_FULL, S_AE, S_AF} sel_t;
    typedef struct {
        int            cyc;
        sel_t          sel;
        logic [RW-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RW-1:0] sig(sel_t s);
        case (s)
            S_RQ0:   return ram_q0;
            S_RQ1:   return ram_q1;
            S_OQ0:   return RW'(occ_q0);
            S_OQ1:   return RW'(occ_q1);
            S_FQ:    return fifo_q;
            S_CNT:   return RW'(fifo_count);
            S_EMP:   return RW'(fifo_empty);
            S_FULL:  return RW'(fifo_full);
            S_AE:    return RW'(fifo_almost_empty);
            default: return RW'(fifo_almost_full);
        endcase
    endfunction

    // Monitor: compares every entry due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (sig(sb[i].sel) !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%0h want=%0h",
                             sb[i].sel.name(), cyc, sig(sb[i].sel), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    // dly=0: check this cycle (post-edge state, current inputs);
    // dly=1: check after the next edge.
    task automatic expect_val(int dly, sel_t s, logic [RW-1:0] v);
        exp_t e;
        e.cyc = cyc + dly;
        e.sel = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_flags(int dly, int cnt);
        expect_val(dly, S_CNT,  RW'(cnt));
        expect_val(dly, S_EMP,  RW'(cnt == 0));
        expect_val(dly, S_FULL, RW'(cnt == 32));
        expect_val(dly, S_AE,   RW'(cnt <= 1));
        expect_val(dly, S_AF,   RW'(cnt >= 16));
    endtask

    initial begin
        rst = 1'b1;
        ram_we0 = 0; ram_we1 = 0; ram_addr0 = '0; ram_addr1 = '0;
        ram_d0 = '0; ram_d1 = '0;
        occ_we0 = 0; occ_we1 = 0; occ_addr0 = '0; occ_addr1 = '0;
        fifo_push = 0; fifo_pop = 0; fifo_d = '0;
        tick();
        tick();
        // reset state
        occ_addr0 = 10'd7; occ_addr1 = 10'd7;
        fifo_flags(0, 0);
        expect_val(0, S_FQ, '0);
        expect_val(0, S_OQ0, '0);
        expect_val(0, S_OQ1, '0);
        rst = 1'b0;

        // ---------------- RAM ----------------
        ram_we0 = 1; ram_addr0 = 10'd5; ram_d0 = 66'h2A;
        tick();
        ram_we0 = 0; ram_addr1 = 10'd5;
        expect_val(1, S_RQ1, 66'h2A);
        tick();
        ram_we0 = 1; ram_addr0 = 10'd5; ram_d0 = 66'h55;   // read-first
        expect_val(1, S_RQ0, 66'h2A);
        tick();
        ram_d0 = 66'h77;                                    // port 1 reads same addr
        expect_val(1, S_RQ0, 66'h55);
        expect_val(1, S_RQ1, 66'h55);
        tick();
        ram_we0 = 1; ram_we1 = 1; ram_addr0 = 10'd9; ram_addr1 = 10'd9;
        ram_d0 = 66'h11; ram_d1 = 66'h3_0000_0000_0000_0022;
        tick();
        ram_we0 = 0; ram_we1 = 0; ram_addr1 = 10'd5;
        expect_val(1, S_RQ0, 66'h3_0000_0000_0000_0022);
        expect_val(1, S_RQ1, 66'h77);
        tick();

        // ---------------- occupancy ----------------
        occ_we0 = 1; occ_addr0 = 10'd7; occ_addr1 = 10'd7;
        expect_val(0, S_OQ1, '0);           // pre-edge value
        tick();
        occ_we0 = 0;
        expect_val(0, S_OQ1, 66'd1);
        tick();
        occ_we0 = 1; occ_we1 = 1;           // double toggle cancels
        expect_val(0, S_OQ0, 66'd1);
        tick();
        occ_we0 = 0; occ_we1 = 0;
        expect_val(0, S_OQ0, 66'd1);
        occ_we1 = 1; occ_addr1 = 10'd100;
        tick();
        occ_we1 = 0;
        expect_val(0, S_OQ1, 66'd1);
        tick();

        // ---------------- FIFO order ----------------
        for (int i = 1; i <= 3; i++) begin
            fifo_push = 1; fifo_d = RW'(i);
            fifo_flags(1, i);
            tick();
        end
        fifo_push = 0;
        for (int i = 1; i <= 3; i++) begin
            fifo_pop = 1;
            expect_val(1, S_FQ, RW'(i));
            fifo_flags(1, 3 - i);
            tick();
        end
        fifo_pop = 0;

        // ---------------- FIFO boundaries ----------------
        for (int i = 0; i < 32; i++) begin
            fifo_push = 1; fifo_d = RW'(100 + i);
            fifo_flags(1, i + 1);
            tick();
        end
        fifo_d = RW'(999);                  // dropped
        fifo_flags(1, 32);
        tick();
        fifo_pop = 1; fifo_d = RW'(555);    // push+pop at full: both taken
        expect_val(1, S_FQ, RW'(100));
        fifo_flags(1, 32);
        tick();
        fifo_push = 0;
        for (int i = 0; i < 32; i++) begin
            expect_val(1, S_FQ, (i < 31) ? RW'(101 + i) : RW'(555));
            fifo_flags(1, 31 - i);
            tick();
        end
        expect_val(1, S_FQ, RW'(555));      // pop on empty: fifo_q holds
        fifo_flags(1, 0);
        tick();
        fifo_pop = 0;

        // ---------------- push+pop at count 4 across wrap ----------------
        for (int i = 0; i < 4; i++) begin
            fifo_push = 1; fifo_d = RW'(200 + i);
            tick();
        end
        fifo_pop = 1;
        for (int i = 0; i < 40; i++) begin
            fifo_d = RW'(300 + i);
            expect_val(1, S_FQ, (i < 4) ? RW'(200 + i) : RW'(300 + i - 4));
            expect_val(1, S_CNT, RW'(4));
            tick();
        end
        fifo_push = 0;
        for (int i = 0; i < 4; i++) begin
            expect_val(1, S_FQ, RW'(336 + i));
            tick();
        end
        fifo_pop = 0;

        // ---------------- mid-operation reset ----------------
        for (int i = 0; i < 10; i++) begin
            fifo_push = 1; fifo_d = RW'(i);
            tick();
        end
        fifo_push = 0;
        fifo_flags(0, 10);
        rst = 1;
        fifo_flags(1, 0);
        expect_val(1, S_FQ, '0);
        tick();
        rst = 0;
        occ_addr0 = 10'd7; occ_addr1 = 10'd100;
        ram_addr0 = 10'd5;
        expect_val(0, S_OQ0, '0);
        expect_val(0, S_OQ1, '0);
        expect_val(1, S_RQ0, 66'h77);       // RAM retained through reset
        tick();
        tick();
        tick();

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
